// File: rtl/helix4_action_merge.sv
// Four-lane action merge: per-lane FIFOs drained round-robin into one registered, lane-tagged output.
// Optional per-lane grant counters on stat_grants when HELIX_MERGE_STATS_EN is defined.

`ifndef HELIX_ACTION_W
`define HELIX_ACTION_W 8
`endif

module helix4_action_merge_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

module helix4_action_merge #(
    parameter int ACTION_W   = `HELIX_ACTION_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               in_valid,
    output logic [3:0]               in_ready,
    input  logic [3:0][ACTION_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACTION_W-1:0]      out_data,
    output logic [1:0]               out_lane
`ifdef HELIX_MERGE_STATS_EN
    ,output logic [3:0][15:0]        stat_grants
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0][CW-1:0]       cnt;
    logic [3:0][ACTION_W-1:0] head;
    logic [3:0]               push, pop, not_empty;
    logic [1:0]               rr_ptr, idx, gnt_lane;
    logic                     gnt_vld, loadable;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_lane
            helix4_action_merge_fifo #(
                .W(ACTION_W), .DEPTH(FIFO_DEPTH), .CW(CW)
            ) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .push     (push[g]),
                .push_data(in_data[g]),
                .pop      (pop[g]),
                .head     (head[g]),
                .count    (cnt[g])
            );
            // Ready looks only at the registered count, so a full FIFO refuses
            // a push even in a cycle where it also pops.
            assign in_ready[g]  = !rst && (cnt[g] != CW'(FIFO_DEPTH));
            assign push[g]      = in_valid[g] && in_ready[g];
            assign not_empty[g] = (cnt[g] != '0);
        end
    endgenerate

    assign loadable = !out_valid || out_ready;

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_lane = rr_ptr;
        idx      = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!gnt_vld && not_empty[idx]) begin
                gnt_vld  = 1'b1;
                gnt_lane = idx;
            end
        end
        gnt_vld = gnt_vld && loadable;
        pop     = gnt_vld ? (4'b0001 << gnt_lane) : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
            rr_ptr    <= '0;
        end else if (loadable) begin
            out_valid <= gnt_vld;
            if (gnt_vld) begin
                out_data <= head[gnt_lane];
                out_lane <= gnt_lane;
                rr_ptr   <= gnt_lane + 2'd1;
            end
        end
    end

`ifdef HELIX_MERGE_STATS_EN
    generate
        for (g = 0; g < 4; g++) begin : g_stat
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    stat_grants[g] <= '0;
                else if (pop[g] && stat_grants[g] != 16'hFFFF)
                    stat_grants[g] <= stat_grants[g] + 16'd1;
            end
        end
    endgenerate
`endif
endmodule

// File: tb/tb_helix4_action_merge.sv
// Directed + randomized bench for helix4_action_merge against a queue-based reference model.
// Stats checks are compiled in only with HELIX_MERGE_STATS_EN.

module tb_helix4_action_merge;
    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        in_valid = '0;
    logic [3:0]        in_ready;
    logic [3:0][W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [W-1:0]      out_data;
    logic [1:0]        out_lane;
`ifdef HELIX_MERGE_STATS_EN
    logic [3:0][15:0]  stat_grants;
`endif

    helix4_action_merge #(.ACTION_W(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_lane (out_lane)
`ifdef HELIX_MERGE_STATS_EN
        ,.stat_grants(stat_grants)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: lane queues, output beat, round-robin pointer, grant tallies.
    typedef logic [W-1:0] q_t[$];
    q_t         mq [4];
    int         rr;
    bit         ov;
    logic [W-1:0] od;
    int         ol;
    int         stats [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            stats[i] = 0;
        end
        rr = 0; ov = 0; od = '0; ol = 0;
    endtask

    // One clock edge worth of behaviour, evaluated from pre-edge state.
    task automatic model_edge();
        bit ld;
        int gl;
        bit [3:0] acc;
        ld = !ov || out_ready;
        gl = -1;
        if (ld)
            for (int k = 0; k < 4; k++)
                if (gl < 0 && mq[(rr + k) % 4].size() > 0) gl = (rr + k) % 4;
        for (int i = 0; i < 4; i++) acc[i] = in_valid[i] && (mq[i].size() < DEPTH);
        if (gl >= 0) begin
            od = mq[gl].pop_front();
            ol = gl;
            ov = 1;
            rr = (gl + 1) % 4;
            if (stats[gl] < 65535) stats[gl]++;
        end else if (ld) begin
            ov = 0;
        end
        for (int i = 0; i < 4; i++) if (acc[i]) mq[i].push_back(in_data[i]);
    endtask

    task automatic check_all();
        logic [3:0] mr;
        for (int i = 0; i < 4; i++) mr[i] = (mq[i].size() != DEPTH);
        chk("out_valid", 32'(out_valid), 32'(ov));
        if (ov) begin
            chk("out_data", 32'(out_data), 32'(od));
            chk("out_lane", 32'(out_lane), 32'(ol));
        end
        chk("in_ready", 32'(in_ready), 32'(mr));
`ifdef HELIX_MERGE_STATS_EN
        for (int i = 0; i < 4; i++) chk("stat_grants", 32'(stat_grants[i]), 32'(stats[i]));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        in_valid = '0;
        #1 rst = 1'b1;
        #1;
        model_clear();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_lane", 32'(out_lane), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
`ifdef HELIX_MERGE_STATS_EN
        chk("rst_stats", 32'(stat_grants[0] | stat_grants[1] | stat_grants[2] | stat_grants[3]), 0);
`endif
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc;
        bit a;
        model_clear();

        // Single lane.
        do_reset();
        out_ready = 1'b1;
        in_valid = 4'b0100; in_data[2] = 8'hA1;
        step();
        chk("single_lat_not_yet", 32'(out_valid), 0);
        in_data[2] = 8'hA2;
        step();
        chk("single_first_data", 32'(out_data), 32'hA1);
        chk("single_first_lane", 32'(out_lane), 2);
        in_valid = '0;
        step();
        chk("single_second_data", 32'(out_data), 32'hA2);
        chk("single_second_lane", 32'(out_lane), 2);
        repeat (3) step();

        // Round-robin fairness.
        do_reset();
        out_ready = 1'b0;
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) in_data[i] = 8'(16 * i);
        step();
        for (int i = 0; i < 4; i++) in_data[i] = 8'(16 * i + 1);
        step();
        in_valid = '0;
        step();
        chk("rr_beat0_lane", 32'(out_lane), 0);
        chk("rr_beat0_data", 32'(out_data), 32'h00);
        out_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            step();
            chk("rr_no_bubble", 32'(out_valid), 1);
            chk("rr_lane_order", 32'(out_lane), 32'(k % 4));
            chk("rr_data", 32'(out_data), 32'(16 * (k % 4) + k / 4));
        end
        step();
        chk("rr_drained", 32'(out_valid), 0);

        // Full / backpressure on lane 1.
        do_reset();
        out_ready = 1'b0;
        in_valid = 4'b0010;
        nacc = 0;
        for (int c = 0; c < 8; c++) begin
            in_data[1] = 8'h50 + 8'(nacc);
            a = in_ready[1];
            step();
            if (a) nacc++;
        end
        chk("full_accepted", 32'(nacc), 5);
        chk("full_ready_low", 32'(in_ready[1]), 0);
        chk("full_hold_data", 32'(out_data), 32'h50);
        in_valid = '0;
        out_ready = 1'b1;
        repeat (7) step();

        // Skip empty lanes, then lane 0 wins from rr_ptr 0.
        do_reset();
        out_ready = 1'b1;
        in_valid = 4'b0001; in_data[0] = 8'h0C;
        step();
        in_valid = '0;
        step();
        chk("skip_lane0_grant", 32'(out_lane), 0);
        in_valid = 4'b1000; in_data[3] = 8'h3C;
        step();
        in_valid = 4'b1001; in_data[0] = 8'h0D; in_data[3] = 8'h3D;
        step();
        chk("skip_to_lane3", 32'(out_lane), 3);
        in_valid = '0;
        step();
        chk("fresh_lane0_wins", 32'(out_lane), 0);
        step();
        chk("then_lane3", 32'(out_lane), 3);
        step();

        // Reset mid-stream with three buffered words and a live beat.
        do_reset();
        out_ready = 1'b0;
        in_valid = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            in_data[2] = 8'hC0 + 8'(c);
            step();
        end
        chk("pre_rst_valid", 32'(out_valid), 1);
        do_reset();
        out_ready = 1'b1;
        repeat (4) step();

`ifdef HELIX_MERGE_STATS_EN
        // Grant counters.
        do_reset();
        out_ready = 1'b1;
        in_valid = 4'b1001; in_data[0] = 8'h01; in_data[3] = 8'h31;
        step();
        in_valid = 4'b0001; in_data[0] = 8'h02;
        step();
        in_data[0] = 8'h03;
        step();
        in_valid = '0;
        repeat (6) step();
        chk("stat_lane0", 32'(stat_grants[0]), 3);
        chk("stat_lane1", 32'(stat_grants[1]), 0);
        chk("stat_lane2", 32'(stat_grants[2]), 0);
        chk("stat_lane3", 32'(stat_grants[3]), 1);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid  = 4'($urandom);
            for (int i = 0; i < 4; i++) in_data[i] = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        in_valid = '0;
        out_ready = 1'b1;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/helix4_action_merge.md
# helix4_action_merge

Merges the four per-die action streams of the quad cluster into a single tagged action stream for the downstream world interface. Each lane has its own small FIFO. A round-robin arbiter drains the FIFOs into one registered output stage. Every output beat carries the index of the lane it came from, so one die's backpressure never stalls the other three beyond their FIFO depth.

## Interface
- ACTION_W, `HELIX_ACTION_W`, width of one action word.
- FIFO_DEPTH, 4, entries per lane FIFO; must be a power of two and at least 2.
- clk  in  1  single clock; all logic rises on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  4  per-lane action valid, driven from the cluster's action_valid.
- in_ready  out  4  per-lane ready; high when that lane's FIFO is not full.
- in_data  in  4×ACTION_W  per-lane action word.
- out_valid  out  1  merged action valid.
- out_ready  in  1  downstream ready.
- out_data  out  ACTION_W  merged action word.
- out_lane  out  2  source lane of out_data.
- stat_grants  out  4×16  per-lane grant counters; present only with HELIX_MERGE_STATS_EN.

## Operation
- Lane FIFO push happens when in_valid[i] && in_ready[i].
- in_ready[i] = (count[i] != FIFO_DEPTH), decoded from registered count only.
- in_ready has no combinational path from out_ready or in_valid.
- A full FIFO refuses a push even if it pops in the same cycle.
- The output stage is one register: out_valid, out_data, out_lane.
- The output register is loadable when !out_valid || out_ready.
- When loadable, the arbiter grants the first non-empty lane, searching upward from rr_ptr modulo 4.
- On a grant: pop that FIFO, load its head into out_data, set out_lane to the lane index, set out_valid to 1.
- rr_ptr advances to (granted lane + 1) mod 4, and only on a grant.
- If the output is loadable and no lane has data: out_valid goes to 0 once the current beat is taken. rr_ptr is unchanged.
- FIFO rules:
  - Pointers wrap at FIFO_DEPTH.
  - count is log2(FIFO_DEPTH)+1 bits wide.
  - A same-cycle push and pop on a non-full FIFO leaves count unchanged.
  - A push into an empty FIFO is not visible to the arbiter until the next cycle; there is no bypass.
- Data is never dropped, duplicated or reordered within a lane.

## Timing
- Values while rst is high:
  - out_valid = 0, out_data = 0, out_lane = 0.
  - in_ready = 4'b0000.
  - All FIFO counts and pointers = 0, rr_ptr = 0.
  - stat_grants = 0.
- Values after rst deasserts: in_ready = 4'b1111 on the first cycle.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N+1. Minimum latency is 2 cycles.
- Throughput: one beat per cycle while out_ready is high and any FIFO is non-empty.
- Hold rule: while out_valid && !out_ready, out_data and out_lane are held stable and no FIFO pops.
- Asserting rst mid-operation discards all buffered and in-flight words immediately, with no completion of the current beat.

## Configuration
- HELIX_MERGE_STATS_EN defined:
  - stat_grants[i] increments by 1 on each grant to lane i.
  - Each counter saturates at 16'hFFFF.
  - Counters clear only on rst.
- HELIX_MERGE_STATS_EN undefined: the stat_grants port and its counters are absent. All other behaviour is identical.

## Test plan
- Single lane: after reset, hold out_ready=1 and push 0xA1, 0xA2 on lane 2 only.
  - Required: out_valid rises 2 cycles after the first push.
  - Required: out_data sequence 0xA1 then 0xA2, out_lane = 2 for both.
- Round-robin fairness: preload all four FIFOs with 2 words each (lane i holds 0x10·i and 0x10·i+1), then raise out_ready=1.
  - Required out_lane order: 0, 1, 2, 3, 0, 1, 2, 3.
  - Required: 8 consecutive beats with no bubble.
- Full/backpressure: hold out_ready=0 and drive in_valid[1]=1 continuously.
  - Required: in_ready[1] drops after 5 accepted words (4 in FIFO + 1 in the output register).
  - Required: out_data stays at the first word.
  - Then raise out_ready: words emerge in order with none lost.
- Skip empty lanes: rr_ptr=1 after a lane-0 grant, and only lane 3 holds data.
  - Required: next out_lane = 3.
  - Required: then a fresh lane-0 word wins over a lane-3 word that arrived on the same cycle.
- Reset mid-stream: assert rst with 3 words buffered and out_valid=1.
  - Required: out_valid=0 and in_ready=0 within the same cycle.
  - Required: after release, in_ready=4'b1111 and no stale word appears.
- Stats (HELIX_MERGE_STATS_EN defined): 3 grants to lane 0 and 1 grant to lane 3.
  - Required: stat_grants = {1, 0, 0, 3} (lane 3 to lane 0).
